div_radix2_axis: RTL
====================

// Module: div_radix2_axis
// PURPOSE
//   Iterative radix-2 restoring unsigned divider with AXI4-Stream-style slave inputs and master output.
//   Responder for the CPU's divide wrapper:
//   - the wrapper sign-corrects operands, pulses divisor/dividend tvalid for one cycle, waits for dout tvalid;
//   - this block accepts both operands, computes one quotient bit per clock, presents {quotient, remainder}.
//   Replaces the vendor divider IP with portable RTL.
// PARAMETERS
//   WIDTH  32  operand width; quotient and remainder are WIDTH bits each, dout is 2*WIDTH
// PORTS
//   clk                     in   1        single clock, all state updates on posedge
//   rst                     in   1        synchronous reset, active-high
//   s_axis_divisor_tdata    in   WIDTH    unsigned divisor
//   s_axis_divisor_tvalid   in   1        divisor valid
//   s_axis_divisor_tready   out  1        divisor accept-ready
//   s_axis_dividend_tdata   in   WIDTH    unsigned dividend
//   s_axis_dividend_tvalid  in   1        dividend valid
//   s_axis_dividend_tready  out  1        dividend accept-ready
//   m_axis_dout_tdata       out  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}
//   m_axis_dout_tvalid      out  1        result valid
//   m_axis_dout_tready      in   1        downstream accept; tie 1 if unused
// BEHAVIOUR
//   Reset: one clock, synchronous, active-high (rst sampled on posedge clk). On a reset edge:
//     state<=IDLE, m_axis_dout_tvalid<=0, m_axis_dout_tdata<=0, counter<=0.
//     Both s_*_tready are forced 0 while rst is high.
//   FSM states IDLE, CALC, DONE.
//     IDLE: both s_*_tready=1 (combinational from state & !rst).
//       Accept only when divisor_tvalid & dividend_tvalid are both high in the same cycle.
//       On accept: latch operands; rem<=0; quo<=dividend; cnt<=0; ->CALC.
//       If only one tvalid is high: nothing is latched; stay IDLE.
//     CALC: both tready=0; one step per clock, WIDTH steps.
//       Step: t = {rem[W-2:0], quo[W-1]} - {1'b0, divisor} as (W+1)-bit subtract.
//       If no borrow: rem<=t[W-1:0], quo<={quo[W-2:0],1}; else rem<={rem[W-2:0],quo[W-1]}, quo<={quo[W-2:0],0}.
//       Partial remainder held W+1 bits internally so no overflow for divisor >= 2^(W-1).
//       cnt increments each step; after step WIDTH-1 (cnt==WIDTH-1): ->DONE.
//       At that same edge: tdata<={quo_next, rem_next}, tvalid<=1.
//     DONE: tvalid=1; tdata held stable until m_axis_dout_tready=1 at a posedge.
//       On that edge: tvalid<=0, ->IDLE. tdata keeps the last value; don't-care when tvalid=0.
//   Latency: operands accepted at edge E; tvalid first high after edge E+WIDTH (32 clocks for W=32).
//     Fixed, data-independent.
//   Throughput: new operands accepted only in IDLE. With tready tied 1, one op per WIDTH+2 clocks.
//     No accept in the DONE->IDLE cycle.
//   Divide by zero: no special case; restoring algorithm yields quotient=all-ones, remainder=dividend,
//     same latency. Dividend=0 -> {0,0}.
//   Inputs with tvalid while not ready (CALC/DONE) are ignored, not queued.
//     The upstream must hold or re-pulse them.
//   rst during CALC/DONE: operation aborted, result discarded, no tvalid pulse; IDLE next cycle.
//   Simultaneous rst and input tvalid: reset wins, nothing accepted.
// TESTING
//   1. rst 1 clk; 100/7 pulsed 1 cycle -> tvalid after 32 clks, tdata={32'd14, 32'd2}.
//   2. 0xFFFFFFFF/1 -> {0xFFFFFFFF, 0}; 0x80000000/0xFFFFFFFF -> {0, 0x80000000};
//      0xFFFFFFFE/0x80000000 -> {1, 0x7FFFFFFE}.
//   3. 1234/0 -> {0xFFFFFFFF, 32'd1234}; 0/5 -> {0,0}; both with 32-clk latency.
//   4. m_axis_dout_tready held 0 for 10 clks after tvalid -> tvalid/tdata stable throughout;
//      tready=1 -> tvalid drops next edge. New op offered during DONE is ignored.
//   5. rst asserted at step 10 of CALC -> no tvalid; next op 9/3 returns {3,0} with full latency.
//   6. Only divisor_tvalid high for 5 clks -> no accept, tready stays 1. Random 10k ops vs
//      reference model (q=a/b, r=a%b; b=0 rule) with random tready backpressure.

Source files
------------

// File: rtl/div_radix2_axis.sv
// Radix-2 restoring unsigned divider with stream handshakes: one quotient bit per clock.
// Latency WIDTH clocks from operand accept to dout valid; operands accepted only in IDLE, result held until dout tready.
module div_radix2_axis #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tvalid,
    input  logic                 m_axis_dout_tready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;

    assign s_axis_divisor_tready  = (state == IDLE) && !rst;
    assign s_axis_dividend_tready = (state == IDLE) && !rst;
    assign accept = (state == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

    // Shifted partial remainder is WIDTH+1 bits wide so divisors >= 2^(WIDTH-1) compare correctly.
    // When it fits, the true difference is below the divisor, so a WIDTH-bit subtract is exact.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dvsr});
    assign diff    = shifted[WIDTH-1:0] - dvsr;
    assign rem_nxt = fits ? diff : shifted[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], fits};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (cnt == LAST_STEP) state_nxt = DONE;
            DONE:    if (m_axis_dout_tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_dout_tvalid <= 1'b0;
            m_axis_dout_tdata  <= '0;
            cnt                <= '0;
            rem                <= '0;
            quo                <= '0;
            dvsr               <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvsr <= s_axis_divisor_tdata;
                        quo  <= s_axis_dividend_tdata;
                        rem  <= '0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        m_axis_dout_tdata  <= {quo_nxt, rem_nxt};
                        m_axis_dout_tvalid <= 1'b1;
                    end
                end
                DONE: begin
                    if (m_axis_dout_tready) m_axis_dout_tvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
